// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RISC-V core and its fetch stage.
package riscv_pkg;

    localparam int unsigned XLEN     = 32;
    localparam logic [31:0] EOF_WORD = 32'hFFFF_FFFF;

    // Major opcode groups (instr[6:0])
    localparam logic [6:0] R_I   = 7'b0110011;
    localparam logic [6:0] I_I   = 7'b0000011;
    localparam logic [6:0] Imm_I = 7'b0010011;
    localparam logic [6:0] S_I   = 7'b0100011;
    localparam logic [6:0] B_I   = 7'b1100011;
    localparam logic [6:0] U_I   = 7'b0110111;
    localparam logic [6:0] J_I   = 7'b1101111;
    localparam logic [6:0] AUIPC = 7'b0010111;

    // Pipeline step encodings of the multicycle core
    typedef enum logic [2:0] {
        IF  = 3'd0,
        ID  = 3'd1,
        EX  = 3'd2,
        MEM = 3'd3,
        WB  = 3'd4
    } stage_e;

endpackage

// File: rtl/riscv_sync_fifo.sv
// Small synchronous FIFO with flush; head entry is readable combinationally.
module riscv_sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    // Pointer/count bookkeeping; flush wins over push and pop
    always_comb begin
        full     = (count_q == (AW+1)'(DEPTH));
        empty    = (count_q == '0);
        do_push  = push && (!full || pop);
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
        head_data = mem_q[rd_ptr_q];
        count     = count_q;
    end

    // Storage array: written on push, no reset needed since count gates validity
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/riscv_fetch_unit.sv
// Decoupled instruction fetch: streams imem words into a prefetch queue and
// hands {instr, pc} to decode; redirects flush, the EOF word stops fetching.
module riscv_fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned IMEM_WORDS = 35,
    parameter int unsigned XLEN       = riscv_pkg::XLEN
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    output logic            imem_rd_en,
    output logic [XLEN-1:0] imem_index,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    output logic            eof,
    output logic [15:0]     fetch_count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            epoch_q, epoch_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic            inflight_epoch_q, inflight_epoch_d;
    logic            inflight_oob_q, inflight_oob_d;
    logic            stop_q, stop_d;
    logic            eof_q, eof_d;
    logic [15:0]     fetch_count_q, fetch_count_d;

    logic [2*XLEN-1:0] fifo_head;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full, fifo_empty;

    logic [XLEN-1:0] ret_word, head_instr, head_pc;
    logic            ret_accept, ret_is_eof, stop_now;
    logic [CW:0]     occupancy;
    logic            in_range, issue, pop;
    logic            unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc[1:0];

    // Issue/return control; occupancy counts the read in flight so the queue
    // can never overflow. An EOF returning this cycle already blocks issue.
    always_comb begin
        imem_index = {2'b00, fetch_pc_q[XLEN-1:2]};
        in_range   = (imem_index < XLEN'(IMEM_WORDS));
        ret_word   = inflight_oob_q ? XLEN'(EOF_WORD) : imem_rdata;
        ret_accept = inflight_q && (inflight_epoch_q == epoch_q) && !stop_q
                     && !redirect_valid && !reset && !fifo_full;
        ret_is_eof = ret_accept && (ret_word == XLEN'(EOF_WORD));
        stop_now   = stop_q || ret_is_eof;
        occupancy  = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
        issue      = !reset && !stop_now && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
        imem_rd_en = issue && in_range;
        head_instr = fifo_head[XLEN-1:0];
        head_pc    = fifo_head[2*XLEN-1:XLEN];
        instr_valid = !fifo_empty;
        pop         = instr_valid && instr_ready;
        instr       = instr_valid ? head_instr : '0;
        instr_pc    = instr_valid ? head_pc : '0;
        eof         = eof_q;
        fetch_count = fetch_count_q;
    end

    // Next-state for PC, epoch tag, in-flight tracking, stop/eof and counter
    always_comb begin
        fetch_pc_d       = fetch_pc_q;
        epoch_d          = epoch_q;
        inflight_d       = issue;
        inflight_pc_d    = inflight_pc_q;
        inflight_epoch_d = inflight_epoch_q;
        inflight_oob_d   = inflight_oob_q;
        stop_d           = stop_now;
        eof_d            = eof_q;
        fetch_count_d    = fetch_count_q;
        if (issue) begin
            fetch_pc_d       = fetch_pc_q + XLEN'(4);
            inflight_pc_d    = fetch_pc_q;
            inflight_epoch_d = epoch_q;
            inflight_oob_d   = !in_range;
        end
        if (pop) begin
            if (head_instr == XLEN'(EOF_WORD)) begin
                eof_d = 1'b1;
            end else begin
                fetch_count_d = fetch_count_q + 16'd1;
            end
        end
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            epoch_d    = ~epoch_q;
            stop_d     = 1'b0;
            eof_d      = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            fetch_pc_q       <= '0;
            epoch_q          <= 1'b0;
            inflight_q       <= 1'b0;
            inflight_pc_q    <= '0;
            inflight_epoch_q <= 1'b0;
            inflight_oob_q   <= 1'b0;
            stop_q           <= 1'b0;
            eof_q            <= 1'b0;
            fetch_count_q    <= '0;
        end else begin
            fetch_pc_q       <= fetch_pc_d;
            epoch_q          <= epoch_d;
            inflight_q       <= inflight_d;
            inflight_pc_q    <= inflight_pc_d;
            inflight_epoch_q <= inflight_epoch_d;
            inflight_oob_q   <= inflight_oob_d;
            stop_q           <= stop_d;
            eof_q            <= eof_d;
            fetch_count_q    <= fetch_count_d;
        end
    end

    riscv_sync_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (CLOCK_50),
        .srst      (reset),
        .push      (ret_accept),
        .push_data ({inflight_pc_q, ret_word}),
        .pop       (pop),
        .flush     (redirect_valid),
        .head_data (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Directed bench for riscv_fetch_unit with a one-cycle-latency imem model.
module tb_riscv_fetch_unit;
    import riscv_pkg::*;

    localparam int DEPTH      = 4;
    localparam int IMEM_WORDS = 35;

    localparam logic [31:0] ADDI = 32'h0010_0093;
    localparam logic [31:0] ADD  = 32'h0020_81B3;
    localparam logic [31:0] SUB  = 32'h4011_8233;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_rd_en;
    logic [31:0] imem_index;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        eof;
    logic [15:0] fetch_count;

    logic [31:0] mem [IMEM_WORDS];
    int          issue_q [$];
    logic [31:0] acc_pc_q [$];
    logic [31:0] acc_instr_q [$];
    int          oob_issues = 0;
    int          total = 0;
    int          bad = 0;
    int          n;

    always #5 clk = ~clk;

    riscv_fetch_unit #(
        .DEPTH      (DEPTH),
        .IMEM_WORDS (IMEM_WORDS),
        .XLEN       (32)
    ) dut (
        .CLOCK_50       (clk),
        .reset          (reset),
        .imem_rd_en     (imem_rd_en),
        .imem_index     (imem_index),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .eof            (eof),
        .fetch_count    (fetch_count)
    );

    // Instruction memory: data valid the cycle after the strobe, junk otherwise
    always @(posedge clk) begin
        if (imem_rd_en) begin
            issue_q.push_back(int'(imem_index));
            if (imem_index < 32'(IMEM_WORDS)) begin
                imem_rdata <= mem[imem_index[5:0]];
            end else begin
                oob_issues++;
                imem_rdata <= 32'hDEAD_BEEF;
            end
        end else begin
            imem_rdata <= 32'hDEAD_BEEF;
        end
    end

    // Log every handshake with the consumer
    always @(posedge clk) begin
        if (!reset && instr_valid && instr_ready) begin
            acc_pc_q.push_back(instr_pc);
            acc_instr_q.push_back(instr);
            $display("accept pc=0x%08h instr=0x%08h", instr_pc, instr);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        issue_q.delete();
        acc_pc_q.delete();
        acc_instr_q.delete();
        oob_issues = 0;
    endtask

    // Leaves the bench at the start of cycle 0 with reset just released
    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic fill_plain();
        for (int i = 0; i < IMEM_WORDS; i++) begin
            mem[i] = NOP | (32'(i) << 20);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;
        fill_plain();
        tick();
        tick();
        #2;
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_rd_en", 32'(imem_rd_en), 32'd0);
        check_eq("rst_eof", 32'(eof), 32'd0);
        check_eq("rst_count", 32'(fetch_count), 32'd0);
        check_eq("rst_instr", instr, 32'd0);
        check_eq("rst_pc", instr_pc, 32'd0);

        // Basic stream: addi/add/sub/EOF
        mem[0] = ADDI; mem[1] = ADD; mem[2] = SUB; mem[3] = EOF_WORD;
        for (int i = 4; i < IMEM_WORDS; i++) mem[i] = NOP;
        do_reset();
        instr_ready = 1'b1;
        #2;
        check_eq("t1_c0_rd_en", 32'(imem_rd_en), 32'd1);
        check_eq("t1_c0_index", imem_index, 32'd0);
        check_eq("t1_c0_valid", 32'(instr_valid), 32'd0);
        tick(); #2;
        check_eq("t1_c1_valid", 32'(instr_valid), 32'd0);
        check_eq("t1_c1_index", imem_index, 32'd1);
        tick(); #2;
        check_eq("t1_c2_valid", 32'(instr_valid), 32'd1);
        check_eq("t1_c2_pc", instr_pc, 32'h0);
        check_eq("t1_c2_instr", instr, ADDI);
        tick(); #2;
        check_eq("t1_c3_pc", instr_pc, 32'h4);
        check_eq("t1_c3_instr", instr, ADD);
        tick(); #2;
        check_eq("t1_c4_pc", instr_pc, 32'h8);
        check_eq("t1_c4_instr", instr, SUB);
        tick(); #2;
        check_eq("t1_c5_pc", instr_pc, 32'hC);
        check_eq("t1_c5_instr", instr, EOF_WORD);
        check_eq("t1_c5_eof", 32'(eof), 32'd0);
        tick(); #2;
        check_eq("t1_c6_valid", 32'(instr_valid), 32'd0);
        check_eq("t1_c6_eof", 32'(eof), 32'd1);
        check_eq("t1_c6_count", 32'(fetch_count), 32'd3);
        repeat (3) tick();
        #2;
        check_eq("t1_idle_valid", 32'(instr_valid), 32'd0);
        check_eq("t1_idle_rd_en", 32'(imem_rd_en), 32'd0);
        check_eq("t1_issues", 32'(issue_q.size()), 32'd4);

        // Redirect while stopped: eof clears, counter keeps going
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        clear_logs();
        #2;
        check_eq("t4_redir_rd_en", 32'(imem_rd_en), 32'd0);
        tick();
        redirect_valid = 1'b0;
        #2;
        check_eq("t4_eof_cleared", 32'(eof), 32'd0);
        check_eq("t4_rd_en", 32'(imem_rd_en), 32'd1);
        check_eq("t4_index", imem_index, 32'd0);
        check_eq("t4_count_kept", 32'(fetch_count), 32'd3);
        n = 0;
        while (!eof && n < 30) begin
            tick(); #2;
            n++;
        end
        check_eq("t4_eof_again", 32'(eof), 32'd1);
        check_eq("t4_count", 32'(fetch_count), 32'd6);
        check_eq("t4_accepts", 32'(acc_pc_q.size()), 32'd4);
        if (acc_pc_q.size() == 4) begin
            check_eq("t4_first_pc", acc_pc_q[0], 32'h0);
            check_eq("t4_last_pc", acc_pc_q[3], 32'hC);
        end

        // Backpressure: queue fills to DEPTH including the in-flight read
        fill_plain();
        do_reset();
        instr_ready = 1'b0;
        repeat (7) tick();
        #2;
        check_eq("t2_issues", 32'(issue_q.size()), 32'd4);
        if (issue_q.size() == 4) begin
            check_eq("t2_first_idx", 32'(issue_q[0]), 32'd0);
            check_eq("t2_last_idx", 32'(issue_q[3]), 32'd3);
        end
        check_eq("t2_full_rd_en", 32'(imem_rd_en), 32'd0);
        check_eq("t2_head_valid", 32'(instr_valid), 32'd1);
        check_eq("t2_head_pc", instr_pc, 32'h0);
        check_eq("t2_head_instr", instr, 32'h0000_0013);
        tick();
        instr_ready = 1'b1;
        #2;
        check_eq("t2_pop_rd_en", 32'(imem_rd_en), 32'd0);
        tick();
        instr_ready = 1'b0;
        #2;
        check_eq("t2_resume_rd_en", 32'(imem_rd_en), 32'd1);
        check_eq("t2_resume_index", imem_index, 32'd4);
        check_eq("t2_new_head_pc", instr_pc, 32'h4);
        check_eq("t2_new_head_instr", instr, 32'h0010_0013);
        tick(); #2;
        check_eq("t2_hold_rd_en", 32'(imem_rd_en), 32'd0);
        tick(); #2;
        check_eq("t2_hold2_rd_en", 32'(imem_rd_en), 32'd0);
        check_eq("t2_issues_after", 32'(issue_q.size()), 32'd5);
        check_eq("t2_count", 32'(fetch_count), 32'd1);

        // Redirect to 0x23 while index 2 is returning
        do_reset();
        instr_ready = 1'b1;
        #2;
        tick();
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h23;
        #2;
        check_eq("t3_redir_rd_en", 32'(imem_rd_en), 32'd0);
        tick();
        redirect_valid = 1'b0;
        #2;
        check_eq("t3_c4_valid", 32'(instr_valid), 32'd0);
        check_eq("t3_c4_rd_en", 32'(imem_rd_en), 32'd1);
        check_eq("t3_c4_index", imem_index, 32'd8);
        check_eq("t3_c4_count", 32'(fetch_count), 32'd2);
        tick(); #2;
        check_eq("t3_c5_valid", 32'(instr_valid), 32'd0);
        tick(); #2;
        check_eq("t3_c6_valid", 32'(instr_valid), 32'd1);
        check_eq("t3_c6_pc", instr_pc, 32'h20);
        check_eq("t3_c6_instr", instr, 32'h0080_0013);
        tick(); #2;
        check_eq("t3_c7_pc", instr_pc, 32'h24);
        check_eq("t3_c7_count", 32'(fetch_count), 32'd3);
        n = 0;
        foreach (acc_pc_q[i]) if (acc_pc_q[i] == 32'h8) n++;
        check_eq("t3_dropped_pc8", 32'(n), 32'd0);
        check_eq("t3_accepts", 32'(acc_pc_q.size()), 32'd3);

        // Run off the end of memory: synthetic EOF at pc 0x8C
        do_reset();
        instr_ready = 1'b1;
        #2;
        n = 0;
        while (!eof && n < 80) begin
            tick(); #2;
            n++;
        end
        check_eq("t5_eof", 32'(eof), 32'd1);
        check_eq("t5_count", 32'(fetch_count), 32'd35);
        check_eq("t5_oob_reads", 32'(oob_issues), 32'd0);
        check_eq("t5_issues", 32'(issue_q.size()), 32'd35);
        check_eq("t5_accepts", 32'(acc_pc_q.size()), 32'd36);
        if (acc_pc_q.size() == 36) begin
            check_eq("t5_last_real_pc", acc_pc_q[34], 32'h88);
            check_eq("t5_last_real_instr", acc_instr_q[34], 32'h0220_0013);
            check_eq("t5_eof_pc", acc_pc_q[35], 32'h8C);
            check_eq("t5_eof_instr", acc_instr_q[35], EOF_WORD);
        end
        tick(); tick(); #2;
        check_eq("t5_idle_valid", 32'(instr_valid), 32'd0);
        check_eq("t5_idle_rd_en", 32'(imem_rd_en), 32'd0);

        // Reset with three entries queued and a read in flight
        do_reset();
        instr_ready = 1'b0;
        #2;
        tick();
        tick();
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        tick();
        tick();
        #2;
        check_eq("t6_pre_count", 32'(fetch_count), 32'd1);
        check_eq("t6_pre_head_pc", instr_pc, 32'h4);
        check_eq("t6_pre_full_rd_en", 32'(imem_rd_en), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_logs();
        #2;
        check_eq("t6_valid", 32'(instr_valid), 32'd0);
        check_eq("t6_count", 32'(fetch_count), 32'd0);
        check_eq("t6_eof", 32'(eof), 32'd0);
        check_eq("t6_rd_en", 32'(imem_rd_en), 32'd1);
        check_eq("t6_index", imem_index, 32'd0);
        tick(); #2;
        check_eq("t6_c1_valid", 32'(instr_valid), 32'd0);
        tick(); #2;
        check_eq("t6_c2_valid", 32'(instr_valid), 32'd1);
        check_eq("t6_c2_pc", instr_pc, 32'h0);
        check_eq("t6_c2_instr", instr, 32'h0000_0013);
        if (issue_q.size() > 0) check_eq("t6_first_issue", 32'(issue_q[0]), 32'd0);
        else check_eq("t6_first_issue_seen", 32'(issue_q.size()), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_fetch_unit.md
Name: riscv_fetch_unit

Overview:
- Decoupled instruction-fetch stage that sits directly upstream of the multicycle RISC-V core's decode step.
- Streams words from instruction memory into a small prefetch queue and hands them to the core as {instr, pc} over a valid/ready handshake.
- Handles PC redirects from branches by flushing the queue and discarding in-flight reads.
- Stops fetching once the all-ones EOF word (32'hFFFF_FFFF) is fetched.

Parameters:
- DEPTH, 4, prefetch queue entries; power of two, minimum 2.
- IMEM_WORDS, 35, instruction-memory size in 32-bit words.
- XLEN, 32, instruction and PC width.

Ports:
- CLOCK_50  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_rd_en  out  1  read strobe to instruction memory.
- imem_index  out  32  word index (byte PC >> 2).
- imem_rdata  in  32  read data; valid exactly one cycle after imem_rd_en.
- redirect_valid  in  1  branch taken; load a new PC this cycle.
- redirect_pc  in  32  byte-address branch target.
- instr_valid  out  1  head-of-queue entry valid.
- instr  out  32  head instruction word.
- instr_pc  out  32  byte PC of the head instruction, i.e. the address it was fetched from (not PC+4).
- instr_ready  in  1  consumer accepts the head entry.
- eof  out  1  sticky; the EOF word has been consumed.
- fetch_count  out  16  instructions accepted by the consumer, excluding EOF.

Behaviour:
- Reset (sampled on a CLOCK_50 edge with reset=1), forcing:
  - fetch_pc=0, queue empty, in-flight=0, epoch=0;
  - instr_valid=0, imem_rd_en=0, eof=0, fetch_count=0, instr/instr_pc=0.
- Reset asserted mid-operation discards everything, including a read in flight.
- Issue rule: imem_rd_en=1 when all of the following hold:
  - occupancy + inflight < DEPTH;
  - stop flag clear;
  - redirect_valid=0;
  - reset=0.
- On each issue, imem_index=fetch_pc>>2, fetch_pc += 4, inflight set, and the PC and current epoch are captured.
- Return: on the cycle after an issue, imem_rdata is pushed with its PC if the captured epoch equals the current epoch; otherwise it is dropped.
- Latency: reset deasserts before cycle 0; the first issue is in cycle 0, the data is pushed at the end of cycle 1, and instr_valid=1 from cycle 2.
- Throughput: sustained 1 instruction per cycle when instr_ready is held high.
- Handshake:
  - pop when instr_valid && instr_ready;
  - instr/instr_pc hold stable while instr_valid=1 and not accepted;
  - push and pop in the same cycle is legal, and occupancy is unchanged.
- Full: occupancy counting includes the in-flight read, so the queue never overflows and rdata is never lost.
- EOF:
  - When a pushed word equals 32'hFFFF_FFFF, set stop; no further issues.
  - The EOF entry is presented like any other entry.
  - Popping it sets eof=1 and does not increment fetch_count.
  - instr_valid stays 0 afterwards until a redirect or reset.
- Out-of-range PC: if fetch_pc>>2 >= IMEM_WORDS, no memory read is made; a synthetic EOF word with that PC is pushed the next cycle under the same rules as a real read.
- Redirect (redirect_valid=1):
  - Queue flushed, epoch toggled (an in-flight read is dropped next cycle).
  - fetch_pc = {redirect_pc[31:2],2'b00}; low bits are ignored.
  - stop and eof are cleared; no issue in the redirect cycle; the first issue is in the next cycle.
  - instr_valid=0 for 2 cycles after the redirect edge.
- Redirect and pop in the same cycle: redirect has priority. The pop still counts (fetch_count++ if not EOF), but the queue is empty afterwards.
- fetch_count wraps modulo 2^16.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN;
  - EOF_WORD=32'hFFFF_FFFF;
  - the opcode localparams (R_I, I_I, Imm_I, S_I, B_I, U_I, J_I, AUIPC);
  - the stage encodings IF..WB.
- One sub-module: riscv_sync_fifo, parameterised width/depth, with push/pop/flush, count, full/empty.
  - The fetch unit instantiates it with width 64 ({pc, instr}).
- Epoch tag, issue control, EOF/stop and the counter stay in the top module.

Test Plan:
- Reset, memory words 0..3 = addi/add/sub/EOF, ready=1 → instr_valid at cycle 2:
  - instr_pc 0,4,8 on consecutive cycles, then EOF at pc 12;
  - eof=1, fetch_count=3; exactly 4 issues.
- ready=0 after reset → exactly DEPTH=4 issues (index 0..3), then imem_rd_en stays 0 and the head holds pc 0. Raise ready → issues resume one per pop.
- Redirect to 0x23 while a read of index 2 is in flight → that word is dropped and the queue is empty. The next issue is index 8 (0x20); the next accepted instr_pc=0x20.
- Redirect while stopped (eof=1) to pc 0 → eof clears, fetch restarts from index 0, and fetch_count continues from its prior value.
- IMEM_WORDS=35 with no EOF in memory, ready=1 → last real pc 0x88, then synthetic EOF with pc 0x8C and eof=1. imem_rd_en is never asserted with index 35.
- Assert reset with 3 entries queued and a read in flight → next cycle instr_valid=0, count 0, eof=0; the first issue after release is index 0.
